mem_port_arbiter: RTL

- Shares the single external memory port between two Cache instances: port 0 is the data cache, port 1 is the instruction cache.
- Each requester sees the same one-cycle-pulse request / mem_done handshake it expects from memory; the arbiter sees it toward memory.
- Each requester gets a depth-1 request buffer and a grant policy (round-robin or fixed priority).
- Only one memory transaction is outstanding at a time, so responses are routed by a single owner register.

---
 rtl/mem_port_arbiter_if.sv | 15 +
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/done memory handshake shared by caches, arbiter and memory
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic [1:0]        rw_flag;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       w_data;
  logic [3:0]        w_mask;
  logic [31:0]       r_data;
  logic              busy;
  logic              done;

  modport master (output rw_flag, addr, w_data, w_mask, input r_data, busy, done);
  modport slave  (input rw_flag, addr, w_data, w_mask, output r_data, busy, done);
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port arbiter in front of a single-outstanding memory port
module mem_port_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int ADDR_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  p0,
  mem_port_arbiter_if.slave  p1,
  mem_port_arbiter_if.master mem,
  output logic               overflow_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e            state_q, state_d;
  logic [1:0]        buf_vld_q, buf_vld_d;
  logic [1:0]        buf_flag_q  [2];
  logic [1:0]        buf_flag_d  [2];
  logic [ADDR_W-1:0] buf_addr_q  [2];
  logic [ADDR_W-1:0] buf_addr_d  [2];
  logic [31:0]       buf_wdata_q [2];
  logic [31:0]       buf_wdata_d [2];
  logic [3:0]        buf_wmask_q [2];
  logic [3:0]        buf_wmask_d [2];
  logic              owner_q, owner_d;
  logic              rr_last_q, rr_last_d;
  logic [1:0]        mem_flag_q, mem_flag_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic              overflow_q, overflow_d;

  logic [1:0]        req_flag  [2];
  logic [ADDR_W-1:0] req_addr  [2];
  logic [31:0]       req_wdata [2];
  logic [3:0]        req_wmask [2];
  logic [1:0]        done_vec;
  logic              winner;

  assign req_flag[0]  = p0.rw_flag;
  assign req_flag[1]  = p1.rw_flag;
  assign req_addr[0]  = p0.addr;
  assign req_addr[1]  = p1.addr;
  assign req_wdata[0] = p0.w_data;
  assign req_wdata[1] = p1.w_data;
  assign req_wmask[0] = p0.w_mask;
  assign req_wmask[1] = p1.w_mask;

  always_comb begin
    done_vec = 2'b00;
    if (state_q == WAIT && mem.done) done_vec[owner_q] = 1'b1;

    if (PRIORITY_MODE == 1)  winner = buf_vld_q[0] ? 1'b0 : 1'b1;
    else if (&buf_vld_q)     winner = ~rr_last_q;
    else                     winner = buf_vld_q[0] ? 1'b0 : 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    buf_vld_d   = buf_vld_q;
    buf_flag_d  = buf_flag_q;
    buf_addr_d  = buf_addr_q;
    buf_wdata_d = buf_wdata_q;
    buf_wmask_d = buf_wmask_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    mem_flag_d  = 2'b00;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE: begin
        if (mem.done) overflow_d = 1'b1;
        if ((|buf_vld_q) && !mem.busy) begin
          owner_d     = winner;
          mem_flag_d  = buf_flag_q[winner];
          mem_addr_d  = buf_addr_q[winner];
          mem_wdata_d = buf_wdata_q[winner];
          mem_wmask_d = buf_wmask_q[winner];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem.done) overflow_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem.done) begin
          buf_vld_d[owner_q] = 1'b0;
          rr_last_d          = owner_q;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture runs after the done clear so a follow-up issued in the done cycle lands.
    for (int n = 0; n < 2; n++) begin
      if (req_flag[n] != 2'b00) begin
        if (!buf_vld_q[n] || done_vec[n]) begin
          buf_vld_d[n]   = 1'b1;
          buf_flag_d[n]  = req_flag[n];
          buf_addr_d[n]  = req_addr[n];
          buf_wdata_d[n] = req_wdata[n];
          buf_wmask_d[n] = req_wmask[n];
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      buf_vld_q   <= 2'b00;
      owner_q     <= 1'b0;
      rr_last_q   <= 1'b1;
      mem_flag_q  <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      overflow_q  <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        buf_flag_q[n]  <= '0;
        buf_addr_q[n]  <= '0;
        buf_wdata_q[n] <= '0;
        buf_wmask_q[n] <= '0;
      end
    end else begin
      state_q     <= state_d;
      buf_vld_q   <= buf_vld_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      mem_flag_q  <= mem_flag_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      overflow_q  <= overflow_d;
      for (int n = 0; n < 2; n++) begin
        buf_flag_q[n]  <= buf_flag_d[n];
        buf_addr_q[n]  <= buf_addr_d[n];
        buf_wdata_q[n] <= buf_wdata_d[n];
        buf_wmask_q[n] <= buf_wmask_d[n];
      end
    end
  end

  assign mem.rw_flag = mem_flag_q;
  assign mem.addr    = mem_addr_q;
  assign mem.w_data  = mem_wdata_q;
  assign mem.w_mask  = mem_wmask_q;
  assign overflow_o  = overflow_q;

  assign p0.busy   = buf_vld_q[0];
  assign p1.busy   = buf_vld_q[1];
  assign p0.done   = done_vec[0];
  assign p1.done   = done_vec[1];
  assign p0.r_data = done_vec[0] ? mem.r_data : 32'h0;
  assign p1.r_data = done_vec[1] ? mem.r_data : 32'h0;
endmodule
